ddr2_cmd_decoder: RTL and testbench
===================================

# ddr2_cmd_decoder

Decodes the DDR2 command/address bus that the PHY drives toward the DRAM: cke, cs_n, ras_n, cas_n, we_n, ba and addr. Sits on the DRAM side of the board interface, in the memory model and in the bench monitor. Outputs decoded commands, per-bank open/closed state, captured mode-register settings, and read/write data-window strobes. Flags protocol violations so the controller/PHY pair can be checked cycle by cycle.

## Interface
- NUM_BANKS, 8, bank count; equals 2**`DRAM_BA_WIDTH
- MAX_LAT, 16, depth of the burst-window shift registers in cycles
- clk  in  1  DRAM clock (ck); all inputs sampled on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cke  in  1  clock enable
- cs_n  in  `DRAM_CS_WIDTH  chip selects; the decoder responds to bit 0 only
- ras_n, cas_n, we_n  in  1 each  command bits
- ba  in  `DRAM_BA_WIDTH  bank address
- addr  in  `DRAM_ADDR_WIDTH  row/column/mode address
- cmd_valid  out  1  pulse: a non-NOP command was decoded
- cmd  out  cmd_t  decoded command
- cmd_ba  out  `DRAM_BA_WIDTH  bank of the decoded command
- cmd_addr  out  `DRAM_ADDR_WIDTH  addr of the decoded command
- cmd_ap  out  1  auto-precharge bit (addr[10]) for RD/WR; all-banks bit for PRE
- bank_open  out  NUM_BANKS  per-bank open flag
- burst_len  out  4  4 or 8
- cas_lat  out  3  CL, 2..6
- add_lat  out  3  AL, 0..5
- rd_window  out  1  high during read-data beats
- wr_window  out  1  high during write-data beats
- err  out  1  pulse on a protocol violation
- err_code  out  err_t  cause, held until the next err

## Operation
- Command valid when cke=1 and cs_n[0]=0. The command is set by {ras_n,cas_n,we_n}:
  - 000: MRS. ba[1:0]=0 is MR, 1 is EMR1, 2 and 3 are EMR2 and EMR3.
  - 001: REF
  - 010: PRE
  - 011: ACT
  - 100: WR
  - 101: RD
  - 110: reserved, raises ERR_RSVD
  - 111: NOP
- cs_n[0]=1 is DESELECT and is treated as NOP.
- cke=0 means power-down: all inputs are ignored and no errors are raised. Pending burst windows still drain.
- Bank state:
  - ACT opens bank ba. ACT to an already open bank raises ERR_ACT_OPEN; the bank stays open.
  - PRE with addr[10]=1 closes all banks. PRE with addr[10]=0 closes bank ba. PRE to a closed bank is legal.
  - RD or WR to a closed bank raises ERR_CLOSED. No window is started.
  - RD or WR with addr[10]=1 closes the bank after issue. A following ACT to that bank is legal from the next cycle.
- MRS and REF with any bank open raise ERR_NOT_IDLE. The register is still written.
- MR fields:
  - addr[2:0]=010 gives BL4; 011 gives BL8; any other value raises ERR_MODE and BL is unchanged.
  - addr[6:4]=2..6 sets CL; any other value raises ERR_MODE.
- EMR1 field: addr[5:3]=0..5 sets AL; 6 or 7 raises ERR_MODE.
- EMR2 and EMR3 are accepted and ignored.
- Latencies: RL = AL+CL, WL = RL-1.
- Windows:
  - RD sets rd_window for BL/2 cycles beginning RL cycles after the sampling edge.
  - WR sets wr_window for BL/2 cycles beginning WL cycles after the sampling edge.
- Back-to-back RD→RD or WR→WR spaced BL/2 cycles gives a seamless window with no gap.
- Any cycle where rd_window and wr_window would both be high raises ERR_BUS_CONFLICT. Both windows stay asserted.
- Simultaneous error sources in one command: the priority is RSVD > CLOSED > ACT_OPEN > NOT_IDLE > MODE. Bus conflict is reported only if no command error occurs in that cycle.

## Timing
- Edge T samples the command. cmd_valid, cmd, cmd_ba, cmd_addr, cmd_ap and err are registered and visible in cycle T+1, for one cycle.
- bank_open and the mode outputs update at edge T+1 together with cmd_valid.
- A new BL or CL applies to commands sampled after the MRS edge.
- Windows are computed from the BL, CL and AL in effect at the RD/WR edge.
- rd_window is high in cycles T+RL .. T+RL+BL/2-1, counting cycle T+1 as the cycle after edge T.
- Latencies above MAX_LAT-1 cannot occur with legal CL and AL values.
- Reset values:
  - cmd_valid=0, cmd=CMD_NOP, cmd_ba=0, cmd_addr=0, cmd_ap=0
  - bank_open=0, rd_window=0, wr_window=0, err=0, err_code=ERR_NONE
  - burst_len=4, cas_lat=3, add_lat=0
- Reset mid-burst clears both windows immediately (asynchronous).

## Structure
- Package ddr2_cmd_pkg holds:
  - cmd_t: NOP, MRS, EMRS1, EMRS2, EMRS3, REF, PRE, ACT, WR, RD, RSVD
  - err_t
  - MR/EMR field bit positions
  - the BL and CL/AL legal-range constants
- Sub-module ddr2_burst_window, instantiated twice (read and write):
  - MAX_LAT-deep shift register
  - inputs: start pulse, latency and beat count
  - output: the window
- Bank-state logic and mode-register logic stay in the top module.

## Test plan
- Reset, then ACT ba=2, then RD ba=2 col=0x10 with defaults (CL3, AL0, BL4):
  - cmd_valid pulses for each command.
  - bank_open=8'b00000100.
  - rd_window is high exactly cycles T+3..T+4.
- MRS addr=0x053 (BL8, CL5), then EMRS1 addr=0x010 (AL2), then ACT and WR:
  - cas_lat=5, add_lat=2, burst_len=8.
  - wr_window is high cycles T+6..T+9.
- RD to a closed bank 5 → err with ERR_CLOSED; no rd_window.
  - Then ACT bank 1 twice → ERR_ACT_OPEN on the second ACT.
- RD bank 0 with addr[10]=1, then ACT bank 0 on the next cycle → no error; bank_open[0] stays 1.
  - Then PRE with addr[10]=1 → bank_open=0.
  - Then REF → no error.
  - REF with bank 3 open → ERR_NOT_IDLE.
- RD then WR two cycles later at BL4, CL3 → windows overlap → ERR_BUS_CONFLICT.
  - cke=0 while holding a command encoding → no cmd_valid.
  - {ras_n,cas_n,we_n}=110 → ERR_RSVD.
- Assert rst_n low during an active rd_window → rd_window drops immediately.
  - After release, cas_lat=3 and bank_open=0.

Source files
------------

// File: rtl/ddr2_cmd_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ddr2_cmd_pkg
//   Shared types and constants for the DDR2 command/address bus decoder:
//   decoded command and error enumerations, MR/EMR1 field positions, the
//   legal ranges of burst length, CAS latency and additive latency, and the
//   reset defaults of the mode outputs.
// ---------------------------------------------------------------------------
`ifndef DRAM_CS_WIDTH
`define DRAM_CS_WIDTH 2
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

package ddr2_cmd_pkg;

    typedef enum logic [3:0] {
        CMD_NOP,
        CMD_MRS,
        CMD_EMRS1,
        CMD_EMRS2,
        CMD_EMRS3,
        CMD_REF,
        CMD_PRE,
        CMD_ACT,
        CMD_WR,
        CMD_RD,
        CMD_RSVD
    } cmd_t;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_RSVD,
        ERR_CLOSED,
        ERR_ACT_OPEN,
        ERR_NOT_IDLE,
        ERR_MODE,
        ERR_BUS_CONFLICT
    } err_t;

    // {ras_n, cas_n, we_n} encodings
    localparam logic [2:0] RCW_MRS  = 3'b000;
    localparam logic [2:0] RCW_REF  = 3'b001;
    localparam logic [2:0] RCW_PRE  = 3'b010;
    localparam logic [2:0] RCW_ACT  = 3'b011;
    localparam logic [2:0] RCW_WR   = 3'b100;
    localparam logic [2:0] RCW_RD   = 3'b101;
    localparam logic [2:0] RCW_RSVD = 3'b110;
    localparam logic [2:0] RCW_NOP  = 3'b111;

    // addr[10]: auto-precharge on RD/WR, all-banks on PRE
    localparam int AP_BIT = 10;

    // MR fields
    localparam int MR_BL_LSB = 0;
    localparam int MR_BL_MSB = 2;
    localparam int MR_CL_LSB = 4;
    localparam int MR_CL_MSB = 6;

    // EMR1 field
    localparam int EMR1_AL_LSB = 3;
    localparam int EMR1_AL_MSB = 5;

    // Legal encodings and ranges
    localparam logic [2:0] MR_BL4_CODE = 3'b010;
    localparam logic [2:0] MR_BL8_CODE = 3'b011;
    localparam logic [3:0] BL_4        = 4'd4;
    localparam logic [3:0] BL_8        = 4'd8;
    localparam logic [2:0] CL_MIN      = 3'd2;
    localparam logic [2:0] CL_MAX      = 3'd6;
    localparam logic [2:0] AL_MAX      = 3'd5;

    // Reset defaults
    localparam logic [3:0] BL_DEFAULT = BL_4;
    localparam logic [2:0] CL_DEFAULT = 3'd3;
    localparam logic [2:0] AL_DEFAULT = 3'd0;

    // Width of read/write latency values (AL+CL tops out at 11)
    localparam int LAT_W = 5;

    function automatic logic cl_legal(input logic [2:0] cl);
        return (cl >= CL_MIN) && (cl <= CL_MAX);
    endfunction

    function automatic logic al_legal(input logic [2:0] al);
        return al <= AL_MAX;
    endfunction

endpackage

// File: rtl/ddr2_cmd_decoder_if.sv
// ---------------------------------------------------------------------------
// ddr2_cmd_decoder_if
//   DDR2 command/address bus as driven by the PHY toward the DRAM.
//   master : the side driving the bus (PHY / bench)
//   slave  : the side observing it (decoder)
//   Signals: cke, cs_n, ras_n, cas_n, we_n, ba, addr
// ---------------------------------------------------------------------------
`ifndef DRAM_CS_WIDTH
`define DRAM_CS_WIDTH 2
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

interface ddr2_cmd_decoder_if;

    logic                        cke;
    logic [`DRAM_CS_WIDTH-1:0]   cs_n;
    logic                        ras_n;
    logic                        cas_n;
    logic                        we_n;
    logic [`DRAM_BA_WIDTH-1:0]   ba;
    logic [`DRAM_ADDR_WIDTH-1:0] addr;

    modport master (
        output cke, cs_n, ras_n, cas_n, we_n, ba, addr
    );

    modport slave (
        input cke, cs_n, ras_n, cas_n, we_n, ba, addr
    );

endinterface

// File: rtl/ddr2_cmd_decoder_burst_window.sv
// ---------------------------------------------------------------------------
// ddr2_burst_window
//   Generates a data-beat window a programmable number of cycles after a
//   start pulse. Each start ORs a mask of future cycles into a shift
//   register, so overlapping or abutting bursts merge without gaps.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     start        1-cycle pulse on the edge that sampled the RD/WR
//     lat          cycles from the sampling edge to the first beat (>=1)
//     beats        number of window cycles (BL/2)
//     window       registered window output
//     window_next  value window takes after the coming edge
// ---------------------------------------------------------------------------
module ddr2_burst_window
    import ddr2_cmd_pkg::*;
#(
    parameter int MAX_LAT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LAT_W-1:0] lat,
    input  logic [2:0]       beats,
    output logic             window,
    output logic             window_next
);

    // pipe_q[j] is the window value for the cycle j+1 cycles after the
    // most recent edge; bit 0 is the current output.
    logic [MAX_LAT-1:0] pipe_q;
    logic [MAX_LAT-1:0] pipe_d;
    logic [MAX_LAT-1:0] start_mask;

    always_comb begin
        start_mask = '0;
        for (int j = 0; j < MAX_LAT; j++) begin
            if (((j + 1) >= int'(lat)) && ((j + 1) < int'(lat) + int'(beats))) begin
                start_mask[j] = 1'b1;
            end
        end
        pipe_d = (pipe_q >> 1) | (start ? start_mask : '0);
    end

    // NOTE: the pending-beat register is reset like any other state so an
    // asynchronous reset kills an in-flight burst at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign window      = pipe_q[0];
    assign window_next = pipe_d[0];

endmodule

// File: rtl/ddr2_cmd_decoder.sv
// ---------------------------------------------------------------------------
// ddr2_cmd_decoder
//   Decodes the DDR2 command/address bus, tracks per-bank open state,
//   captures MR/EMR1 settings, produces read/write data-window strobes and
//   flags protocol violations.
//   Ports:
//     clk, rst_n         DRAM clock, asynchronous active-low reset
//     bus                command/address bus (slave modport)
//     cmd_valid          pulse: non-NOP command decoded
//     cmd, cmd_ba,
//     cmd_addr, cmd_ap   decoded command and its bank/address/AP bit
//     bank_open          per-bank open flags
//     burst_len,
//     cas_lat, add_lat   current mode-register settings
//     rd_window,
//     wr_window          read/write data-beat windows
//     err, err_code      violation pulse and its held cause
// ---------------------------------------------------------------------------
`ifndef DRAM_CS_WIDTH
`define DRAM_CS_WIDTH 2
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

module ddr2_cmd_decoder
    import ddr2_cmd_pkg::*;
#(
    parameter int NUM_BANKS = 8,
    parameter int MAX_LAT   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ddr2_cmd_decoder_if.slave           bus,
    output logic                        cmd_valid,
    output cmd_t                        cmd,
    output logic [`DRAM_BA_WIDTH-1:0]   cmd_ba,
    output logic [`DRAM_ADDR_WIDTH-1:0] cmd_addr,
    output logic                        cmd_ap,
    output logic [NUM_BANKS-1:0]        bank_open,
    output logic [3:0]                  burst_len,
    output logic [2:0]                  cas_lat,
    output logic [2:0]                  add_lat,
    output logic                        rd_window,
    output logic                        wr_window,
    output logic                        err,
    output err_t                        err_code
);

    // Only chip select 0 is decoded; the others are observed but unused.
    logic unused_cs;
    assign unused_cs = ^bus.cs_n;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic cmd_en;
    cmd_t dec_cmd;

    assign cmd_en = bus.cke & ~bus.cs_n[0];

    // NOTE: every always_comb output gets a default before any branch so
    // no path leaves it unassigned (which would infer a latch).
    always_comb begin
        dec_cmd = CMD_NOP;
        if (cmd_en) begin
            unique case ({bus.ras_n, bus.cas_n, bus.we_n})
                RCW_MRS: begin
                    unique case (bus.ba[1:0])
                        2'd0: dec_cmd = CMD_MRS;
                        2'd1: dec_cmd = CMD_EMRS1;
                        2'd2: dec_cmd = CMD_EMRS2;
                        2'd3: dec_cmd = CMD_EMRS3;
                    endcase
                end
                RCW_REF:  dec_cmd = CMD_REF;
                RCW_PRE:  dec_cmd = CMD_PRE;
                RCW_ACT:  dec_cmd = CMD_ACT;
                RCW_WR:   dec_cmd = CMD_WR;
                RCW_RD:   dec_cmd = CMD_RD;
                RCW_RSVD: dec_cmd = CMD_RSVD;
                RCW_NOP:  dec_cmd = CMD_NOP;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bank state, mode registers and command errors
    // ------------------------------------------------------------------
    logic [NUM_BANKS-1:0] bank_d;
    logic [3:0]           bl_d;
    logic [2:0]           cl_d;
    logic [2:0]           al_d;
    err_t                 cmd_err;
    logic                 rd_start;
    logic                 wr_start;
    logic                 mode_bad;
    logic                 bank_hit;
    logic                 any_open;
    logic                 ap;
    logic [2:0]           bl_field;
    logic [2:0]           cl_field;
    logic [2:0]           al_field;

    assign bank_hit = bank_open[bus.ba];
    assign any_open = |bank_open;
    assign ap       = bus.addr[AP_BIT];
    assign bl_field = bus.addr[MR_BL_MSB:MR_BL_LSB];
    assign cl_field = bus.addr[MR_CL_MSB:MR_CL_LSB];
    assign al_field = bus.addr[EMR1_AL_MSB:EMR1_AL_LSB];

    always_comb begin
        bank_d   = bank_open;
        bl_d     = burst_len;
        cl_d     = cas_lat;
        al_d     = add_lat;
        cmd_err  = ERR_NONE;
        rd_start = 1'b0;
        wr_start = 1'b0;
        mode_bad = 1'b0;

        unique case (dec_cmd)
            CMD_RSVD: cmd_err = ERR_RSVD;

            CMD_ACT: begin
                if (bank_hit) cmd_err = ERR_ACT_OPEN;
                bank_d[bus.ba] = 1'b1;
            end

            CMD_PRE: begin
                if (ap) bank_d = '0;
                else    bank_d[bus.ba] = 1'b0;
            end

            CMD_RD, CMD_WR: begin
                if (!bank_hit) begin
                    cmd_err = ERR_CLOSED;
                end else begin
                    rd_start = (dec_cmd == CMD_RD);
                    wr_start = (dec_cmd == CMD_WR);
                    // Auto-precharge: the bank reads as closed to the
                    // very next command.
                    if (ap) bank_d[bus.ba] = 1'b0;
                end
            end

            CMD_REF: begin
                if (any_open) cmd_err = ERR_NOT_IDLE;
            end

            CMD_MRS: begin
                // Each field updates independently; an illegal field keeps
                // its previous value.
                if (bl_field == MR_BL4_CODE)      bl_d = BL_4;
                else if (bl_field == MR_BL8_CODE) bl_d = BL_8;
                else                              mode_bad = 1'b1;
                if (cl_legal(cl_field)) cl_d = cl_field;
                else                    mode_bad = 1'b1;
                if (any_open)      cmd_err = ERR_NOT_IDLE;
                else if (mode_bad) cmd_err = ERR_MODE;
            end

            CMD_EMRS1: begin
                if (al_legal(al_field)) al_d = al_field;
                else                    mode_bad = 1'b1;
                if (any_open)      cmd_err = ERR_NOT_IDLE;
                else if (mode_bad) cmd_err = ERR_MODE;
            end

            CMD_EMRS2, CMD_EMRS3: begin
                if (any_open) cmd_err = ERR_NOT_IDLE;
            end

            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Data windows, timed from the settings in effect at the RD/WR edge
    // ------------------------------------------------------------------
    logic [LAT_W-1:0] rd_lat;
    logic [LAT_W-1:0] wr_lat;
    logic [2:0]       beats;
    logic             rd_next;
    logic             wr_next;

    assign rd_lat = LAT_W'(add_lat) + LAT_W'(cas_lat);
    assign wr_lat = rd_lat - LAT_W'(1);
    assign beats  = 3'(burst_len >> 1);

    ddr2_burst_window #(.MAX_LAT(MAX_LAT)) u_rd_window (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (rd_start),
        .lat         (rd_lat),
        .beats       (beats),
        .window      (rd_window),
        .window_next (rd_next)
    );

    ddr2_burst_window #(.MAX_LAT(MAX_LAT)) u_wr_window (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (wr_start),
        .lat         (wr_lat),
        .beats       (beats),
        .window      (wr_window),
        .window_next (wr_next)
    );

    // Conflict is flagged in the same cycle both windows are high, and is
    // masked by any command error and by power-down.
    err_t err_d;

    always_comb begin
        err_d = cmd_err;
        if ((cmd_err == ERR_NONE) && bus.cke && rd_next && wr_next) begin
            err_d = ERR_BUS_CONFLICT;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its sources.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd       <= CMD_NOP;
            cmd_ba    <= '0;
            cmd_addr  <= '0;
            cmd_ap    <= 1'b0;
            bank_open <= '0;
            burst_len <= BL_DEFAULT;
            cas_lat   <= CL_DEFAULT;
            add_lat   <= AL_DEFAULT;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            cmd_valid <= (dec_cmd != CMD_NOP);
            cmd       <= dec_cmd;
            if (dec_cmd != CMD_NOP) begin
                cmd_ba   <= bus.ba;
                cmd_addr <= bus.addr;
            end
            cmd_ap    <= ap && (dec_cmd inside {CMD_RD, CMD_WR, CMD_PRE});
            bank_open <= bank_d;
            burst_len <= bl_d;
            cas_lat   <= cl_d;
            add_lat   <= al_d;
            err       <= (err_d != ERR_NONE);
            if (err_d != ERR_NONE) err_code <= err_d;
        end
    end

endmodule

// File: tb/tb_ddr2_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_ddr2_cmd_decoder
//   Self-checking bench for ddr2_cmd_decoder: a table of single commands
//   with expected decode/bank/mode/error results, plus hand-written
//   sequences for burst windows, auto-precharge, bus conflict and reset.
// ---------------------------------------------------------------------------
`ifndef DRAM_CS_WIDTH
`define DRAM_CS_WIDTH 2
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

module tb_ddr2_cmd_decoder;
    import ddr2_cmd_pkg::*;

    logic clk;
    logic rst_n;

    ddr2_cmd_decoder_if bus();

    logic                        cmd_valid;
    cmd_t                        cmd;
    logic [`DRAM_BA_WIDTH-1:0]   cmd_ba;
    logic [`DRAM_ADDR_WIDTH-1:0] cmd_addr;
    logic                        cmd_ap;
    logic [7:0]                  bank_open;
    logic [3:0]                  burst_len;
    logic [2:0]                  cas_lat;
    logic [2:0]                  add_lat;
    logic                        rd_window;
    logic                        wr_window;
    logic                        err;
    err_t                        err_code;

    ddr2_cmd_decoder #(.NUM_BANKS(8), .MAX_LAT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ba    (cmd_ba),
        .cmd_addr  (cmd_addr),
        .cmd_ap    (cmd_ap),
        .bank_open (bank_open),
        .burst_len (burst_len),
        .cas_lat   (cas_lat),
        .add_lat   (add_lat),
        .rd_window (rd_window),
        .wr_window (wr_window),
        .err       (err),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cke, input logic cs_n0, input logic [2:0] rcw,
                         input logic [2:0] ba, input logic [13:0] addr);
        bus.cke   = cke;
        bus.cs_n  = '1;
        bus.cs_n[0] = cs_n0;
        {bus.ras_n, bus.cas_n, bus.we_n} = rcw;
        bus.ba    = ba;
        bus.addr  = addr;
    endtask

    task automatic issue(input logic [2:0] rcw, input logic [2:0] ba, input logic [13:0] addr);
        drive(1'b1, 1'b0, rcw, ba, addr);
    endtask

    task automatic nop();
        drive(1'b1, 1'b1, RCW_NOP, 3'd0, 14'd0);
    endtask

    // Record outputs over n cycles; bit k is the k-th observed cycle,
    // starting with the current one at k=1. Inputs are held at NOP.
    task automatic watch(input int n, output logic [31:0] rd_h, output logic [31:0] wr_h,
                         output logic [31:0] err_h, output logic [31:0] val_h);
        rd_h = '0; wr_h = '0; err_h = '0; val_h = '0;
        for (int k = 1; k <= n; k++) begin
            rd_h[k]  = rd_window;
            wr_h[k]  = wr_window;
            err_h[k] = err;
            val_h[k] = cmd_valid;
            if (k < n) tick();
        end
    endtask

    typedef struct {
        logic       cke;
        logic       cs_n0;
        logic [2:0] rcw;
        logic [2:0] ba;
        logic [13:0] addr;
        logic       e_valid;
        cmd_t       e_cmd;
        logic       e_err;
        err_t       e_code;
        logic [7:0] e_bank;
        logic [3:0] e_bl;
        logic [2:0] e_cl;
        logic [2:0] e_al;
    } vec_t;

    function automatic vec_t mk(input logic cke, input logic cs_n0, input logic [2:0] rcw,
                                input logic [2:0] ba, input logic [13:0] addr,
                                input logic ev, input cmd_t ec, input logic ee, input err_t ecode,
                                input logic [7:0] eb, input logic [3:0] ebl,
                                input logic [2:0] ecl, input logic [2:0] eal);
        vec_t v;
        v.cke = cke; v.cs_n0 = cs_n0; v.rcw = rcw; v.ba = ba; v.addr = addr;
        v.e_valid = ev; v.e_cmd = ec; v.e_err = ee; v.e_code = ecode;
        v.e_bank = eb; v.e_bl = ebl; v.e_cl = ecl; v.e_al = eal;
        return v;
    endfunction

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd_h, wr_h, err_h, val_h;

        // cke cs rcw ba addr | valid cmd err code bank bl cl al
        vecs[0]  = mk(1, 0, RCW_PRE,  0, 14'h400, 1, CMD_PRE,   0, ERR_NONE,     8'h00, 4'd8, 3'd5, 3'd2);
        vecs[1]  = mk(1, 0, RCW_MRS,  0, 14'h032, 1, CMD_MRS,   0, ERR_NONE,     8'h00, 4'd4, 3'd3, 3'd2);
        vecs[2]  = mk(1, 0, RCW_MRS,  1, 14'h000, 1, CMD_EMRS1, 0, ERR_NONE,     8'h00, 4'd4, 3'd3, 3'd0);
        vecs[3]  = mk(1, 0, RCW_RD,   5, 14'h020, 1, CMD_RD,    1, ERR_CLOSED,   8'h00, 4'd4, 3'd3, 3'd0);
        vecs[4]  = mk(1, 0, RCW_ACT,  1, 14'h055, 1, CMD_ACT,   0, ERR_CLOSED,   8'h02, 4'd4, 3'd3, 3'd0);
        vecs[5]  = mk(1, 0, RCW_ACT,  1, 14'h055, 1, CMD_ACT,   1, ERR_ACT_OPEN, 8'h02, 4'd4, 3'd3, 3'd0);
        vecs[6]  = mk(1, 0, RCW_REF,  0, 14'h000, 1, CMD_REF,   1, ERR_NOT_IDLE, 8'h02, 4'd4, 3'd3, 3'd0);
        vecs[7]  = mk(1, 0, RCW_PRE,  1, 14'h000, 1, CMD_PRE,   0, ERR_NOT_IDLE, 8'h00, 4'd4, 3'd3, 3'd0);
        vecs[8]  = mk(1, 0, RCW_REF,  0, 14'h000, 1, CMD_REF,   0, ERR_NOT_IDLE, 8'h00, 4'd4, 3'd3, 3'd0);
        vecs[9]  = mk(1, 0, RCW_PRE,  3, 14'h000, 1, CMD_PRE,   0, ERR_NOT_IDLE, 8'h00, 4'd4, 3'd3, 3'd0);
        vecs[10] = mk(1, 0, RCW_RSVD, 0, 14'h000, 1, CMD_RSVD,  1, ERR_RSVD,     8'h00, 4'd4, 3'd3, 3'd0);
        vecs[11] = mk(0, 0, RCW_ACT,  4, 14'h000, 0, CMD_NOP,   0, ERR_RSVD,     8'h00, 4'd4, 3'd3, 3'd0);
        vecs[12] = mk(1, 1, RCW_ACT,  4, 14'h000, 0, CMD_NOP,   0, ERR_RSVD,     8'h00, 4'd4, 3'd3, 3'd0);
        vecs[13] = mk(1, 0, RCW_MRS,  0, 14'h031, 1, CMD_MRS,   1, ERR_MODE,     8'h00, 4'd4, 3'd3, 3'd0);
        vecs[14] = mk(1, 0, RCW_MRS,  0, 14'h072, 1, CMD_MRS,   1, ERR_MODE,     8'h00, 4'd4, 3'd3, 3'd0);
        vecs[15] = mk(1, 0, RCW_MRS,  1, 14'h030, 1, CMD_EMRS1, 1, ERR_MODE,     8'h00, 4'd4, 3'd3, 3'd0);
        vecs[16] = mk(1, 0, RCW_MRS,  2, 14'h3ff, 1, CMD_EMRS2, 0, ERR_MODE,     8'h00, 4'd4, 3'd3, 3'd0);
        vecs[17] = mk(1, 0, RCW_ACT,  3, 14'h010, 1, CMD_ACT,   0, ERR_MODE,     8'h08, 4'd4, 3'd3, 3'd0);
        vecs[18] = mk(1, 0, RCW_MRS,  0, 14'h042, 1, CMD_MRS,   1, ERR_NOT_IDLE, 8'h08, 4'd4, 3'd4, 3'd0);
        vecs[19] = mk(1, 0, RCW_MRS,  0, 14'h031, 1, CMD_MRS,   1, ERR_NOT_IDLE, 8'h08, 4'd4, 3'd3, 3'd0);
        vecs[20] = mk(1, 0, RCW_PRE,  0, 14'h400, 1, CMD_PRE,   0, ERR_NOT_IDLE, 8'h00, 4'd4, 3'd3, 3'd0);
        vecs[21] = mk(1, 0, RCW_REF,  0, 14'h000, 1, CMD_REF,   0, ERR_NOT_IDLE, 8'h00, 4'd4, 3'd3, 3'd0);

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        nop();
        repeat (3) tick();
        check("rst cmd_valid", cmd_valid, 0);
        check("rst cmd",       cmd, CMD_NOP);
        check("rst cmd_ba",    cmd_ba, 0);
        check("rst cmd_addr",  cmd_addr, 0);
        check("rst cmd_ap",    cmd_ap, 0);
        check("rst bank_open", bank_open, 0);
        check("rst windows",   {rd_window, wr_window}, 0);
        check("rst err",       err, 0);
        check("rst err_code",  err_code, ERR_NONE);
        check("rst modes",     {burst_len, cas_lat, add_lat}, {4'd4, 3'd3, 3'd0});
        #2 rst_n = 1'b1;
        tick();

        // ---------------- ACT + RD, defaults CL3 AL0 BL4 ----------------
        issue(RCW_ACT, 3'd2, 14'h100);
        tick();
        check("act valid", cmd_valid, 1);
        check("act cmd",   cmd, CMD_ACT);
        check("act ba",    cmd_ba, 2);
        check("act bank",  bank_open, 8'b0000_0100);
        issue(RCW_RD, 3'd2, 14'h010);
        tick();
        check("rd cmd",  cmd, CMD_RD);
        check("rd addr", cmd_addr, 14'h010);
        check("rd ap",   cmd_ap, 0);
        nop();
        watch(12, rd_h, wr_h, err_h, val_h);
        check("rd1 rd_window", rd_h, 32'h0000_0018);   // cycles T+3..T+4
        check("rd1 wr_window", wr_h, 0);
        check("rd1 err",       err_h, 0);
        check("rd1 valid pulse", val_h, 32'h0000_0002);

        // ---------------- MRS BL8 CL5, EMRS1 AL2, ACT, WR ----------------
        issue(RCW_PRE, 3'd0, 14'h400);
        tick();
        check("pre all bank", bank_open, 0);
        issue(RCW_MRS, 3'd0, 14'h053);
        tick();
        check("mrs cl", cas_lat, 5);
        check("mrs bl", burst_len, 8);
        check("mrs err", err, 0);
        issue(RCW_MRS, 3'd1, 14'h010);
        tick();
        check("emrs1 cmd", cmd, CMD_EMRS1);
        check("emrs1 al",  add_lat, 2);
        issue(RCW_ACT, 3'd0, 14'h000);
        tick();
        issue(RCW_WR, 3'd0, 14'h008);
        tick();
        check("wr cmd", cmd, CMD_WR);
        nop();
        watch(14, rd_h, wr_h, err_h, val_h);
        check("wr1 wr_window", wr_h, 32'h0000_03C0);   // cycles T+6..T+9
        check("wr1 rd_window", rd_h, 0);
        check("wr1 err",       err_h, 0);

        // ---------------- single-command table ----------------
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].cke, vecs[i].cs_n0, vecs[i].rcw, vecs[i].ba, vecs[i].addr);
            tick();
            check($sformatf("v%0d cmd_valid", i), cmd_valid, vecs[i].e_valid);
            check($sformatf("v%0d cmd", i),       cmd,       vecs[i].e_cmd);
            check($sformatf("v%0d err", i),       err,       vecs[i].e_err);
            check($sformatf("v%0d err_code", i),  err_code,  vecs[i].e_code);
            check($sformatf("v%0d bank_open", i), bank_open, vecs[i].e_bank);
            check($sformatf("v%0d burst_len", i), burst_len, vecs[i].e_bl);
            check($sformatf("v%0d cas_lat", i),   cas_lat,   vecs[i].e_cl);
            check($sformatf("v%0d add_lat", i),   add_lat,   vecs[i].e_al);
            check($sformatf("v%0d rd_window", i), rd_window, 0);
        end
        nop();
        tick();

        // ---------------- RD with auto-precharge then ACT next cycle ----------------
        issue(RCW_ACT, 3'd0, 14'h000);
        tick();
        issue(RCW_RD, 3'd0, 14'h400);
        tick();
        check("rdap cmd_ap", cmd_ap, 1);
        check("rdap bank",   bank_open, 0);
        issue(RCW_ACT, 3'd0, 14'h000);
        tick();
        check("act after ap err",  err, 0);
        check("act after ap bank", bank_open, 8'h01);
        nop();
        watch(8, rd_h, wr_h, err_h, val_h);             // k=1 is cycle T+2
        check("rdap rd_window", rd_h, 32'h0000_000C);
        issue(RCW_PRE, 3'd0, 14'h400);
        tick();
        check("pre all again", bank_open, 0);

        // ---------------- RD then WR two cycles later: bus conflict ----------------
        issue(RCW_ACT, 3'd0, 14'h000);
        tick();
        issue(RCW_RD, 3'd0, 14'h000);
        tick();
        rd_h = '0; wr_h = '0; err_h = '0; val_h = '0;
        for (int k = 1; k <= 10; k++) begin
            rd_h[k]  = rd_window;
            wr_h[k]  = wr_window;
            err_h[k] = err;
            val_h[k] = cmd_valid;
            if (k == 2) issue(RCW_WR, 3'd0, 14'h000);
            else        nop();
            tick();
        end
        check("conf rd_window", rd_h,  32'h0000_0018);
        check("conf wr_window", wr_h,  32'h0000_0030);
        check("conf err",       err_h, 32'h0000_0010);
        check("conf valid",     val_h, 32'h0000_000A);
        check("conf err_code",  err_code, ERR_BUS_CONFLICT);

        // ---------------- reset during an active read window ----------------
        issue(RCW_PRE, 3'd0, 14'h400);
        tick();
        issue(RCW_MRS, 3'd0, 14'h052);
        tick();
        check("mrs cl5", cas_lat, 5);
        issue(RCW_ACT, 3'd0, 14'h000);
        tick();
        issue(RCW_RD, 3'd0, 14'h000);
        tick();
        nop();
        repeat (4) tick();
        check("pre-reset rd_window", rd_window, 1);      // cycle T+5
        #2 rst_n = 1'b0;
        #1;
        check("async rst rd_window", rd_window, 0);
        check("async rst bank", bank_open, 0);
        #3 rst_n = 1'b1;
        tick();
        check("post rst cas_lat",   cas_lat, 3);
        check("post rst bank_open", bank_open, 0);
        check("post rst rd_window", rd_window, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
